dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data memory of the mips core. It shares the memory between the CPU load/store port (m0) and a debug/loader port (m1), which preloads and inspects memory without hierarchical writes. Each access runs a fixed 3-state sequence with a one-cycle ack handshake, and the block drives a stall signal back to the CPU pipeline.

---
 rtl/dm_arbiter.sv | 134 +++++++++++++
 tb/tb_dm_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer for the single-port data memory.
//   m0 = CPU load/store port, m1 = debug/loader port. Each access runs
//   IDLE -> ISSUE -> RESP, with a one-cycle ack pulse in RESP.
// Ports:
//   clk, rst (synchronous, active-low)
//   mX_req/we/be/addr/wdata  request from port X, held until mX_ack
//   mX_ack, mX_rdata         completion pulse and read data (0 unless read ack)
//   m0_stall                 m0_req & ~m0_ack, pipeline freeze
//   mem_en/we/be/addr/wdata  registered memory command (mem_en high in ISSUE)
//   mem_rdata                synchronous memory read data (valid in RESP)
//   busy                     high in ISSUE and RESP
// Configuration:
//   DMARB_CPU_PRI_EN defined   -> fixed priority, m0 wins every tie
//   DMARB_CPU_PRI_EN undefined -> round-robin on a `last` register (reset 1)
module dm_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_stall,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   win;      // port being served: 0 = m0, 1 = m1
  logic   grant;    // port that would win if sampled this cycle
`ifndef DMARB_CPU_PRI_EN
  logic   last;     // most recently granted port
`endif

  logic            sel_we;
  logic [DW/8-1:0] sel_be;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  always_comb begin
`ifdef DMARB_CPU_PRI_EN
    grant = ~m0_req;
`else
    if (m0_req && m1_req) grant = ~last;
    else                  grant = ~m0_req;
`endif
  end

  always_comb begin
    sel_we    = grant ? m1_we    : m0_we;
    sel_be    = grant ? m1_be    : m0_be;
    sel_addr  = grant ? m1_addr  : m0_addr;
    sel_wdata = grant ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      win       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      busy      <= 1'b0;
`ifndef DMARB_CPU_PRI_EN
      last      <= 1'b1;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            win       <= grant;
            mem_we    <= sel_we;
            mem_be    <= sel_we ? sel_be : '0;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
`ifndef DMARB_CPU_PRI_EN
            last      <= grant;
`endif
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          m0_ack <= ~win;
          m1_ack <= win;
          state  <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data arrives the cycle after mem_en, i.e. alongside the
  // registered ack, so rdata is a gated pass-through rather than a register.
  assign m0_rdata = (m0_ack && !mem_we) ? mem_rdata : '0;
  assign m1_rdata = (m1_ack && !mem_we) ? mem_rdata : '0;
  assign m0_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, busy;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port synchronous memory with byte-merge writes.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input logic req, input logic we, input logic [3:0] be,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // One access from an idle arbiter with the other port quiet:
  // mem_en one cycle after the sample edge, ack the cycle after that.
  task automatic do_access(input string tag, input bit port, input logic we, input logic [3:0] be,
                           input logic [9:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    int unsigned ack_n = 0;
    int unsigned en_n  = 0;
    logic [3:0]  exp_be;
    logic        ack, oack;
    logic [31:0] rd, ord;
    exp_be = we ? be : 4'h0;
    drive(port, 1'b1, we, be, addr, wdata);
    for (int unsigned n = 1; n <= 10 && ack_n == 0; n++) begin
      @(negedge clk);
      if (mem_en && en_n == 0) begin
        en_n = n;
        chk({tag, ".mem_we"},   32'(mem_we),   32'(we));
        chk({tag, ".mem_be"},   32'(mem_be),   32'(exp_be));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, ".busy"},     32'(busy),     32'd1);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
      end
      ack  = port ? m1_ack   : m0_ack;
      oack = port ? m0_ack   : m1_ack;
      rd   = port ? m1_rdata : m0_rdata;
      ord  = port ? m0_rdata : m1_rdata;
      if (ack) begin
        ack_n = n;
        chk({tag, ".rdata"},       rd,  we ? 32'h0 : exp_rd);
        chk({tag, ".other_ack"},   32'(oack), 32'd0);
        chk({tag, ".other_rdata"}, ord, 32'h0);
        chk({tag, ".mem_en_rsp"},  32'(mem_en), 32'd0);
        if (!port) chk({tag, ".stall_at_ack"}, 32'(m0_stall), 32'd0);
      end
    end
    chk({tag, ".en_cycle"},  en_n,  32'd1);
    chk({tag, ".ack_cycle"}, ack_n, 32'd2);
    drive(port, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    @(negedge clk);
    chk({tag, ".ack_clear"}, 32'(port ? m1_ack : m0_ack), 32'd0);
    chk({tag, ".busy_clear"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit          port;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic exp0, exp1;

    vecs[0]  = '{1'b0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 10'h010, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 4'hF, 10'h004, 32'h12345678, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'h2, 10'h004, 32'h0000AB00, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 10'h004, 32'h0,        32'h1234AB78};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 10'h010, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 10'h3FF, 32'h0F0F0F0F, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 4'h9, 10'h3FF, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0,        32'hA50F0FA5};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 10'h020, 32'h0,        32'h11111111};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 10'h004, 32'h0,        32'h1234AB78};

    // Reset held with both ports requesting: nothing may move.
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 4'hF, 10'h020, 32'h11111111);
    drive(1'b1, 1'b1, 1'b1, 4'hF, 10'h021, 32'h22222222);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.mem_en",   32'(mem_en), 32'd0);
      chk("rst.m0_ack",   32'(m0_ack), 32'd0);
      chk("rst.m1_ack",   32'(m1_ack), 32'd0);
      chk("rst.busy",     32'(busy),   32'd0);
      chk("rst.m0_rdata", m0_rdata,    32'h0);
      chk("rst.m1_rdata", m1_rdata,    32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel.mem_en",   32'(mem_en),   32'd1);
    chk("rst_rel.mem_addr", 32'(mem_addr), 32'h020);
    @(negedge clk);
    chk("rst_rel.m0_ack", 32'(m0_ack), 32'd1);
    chk("rst_rel.m1_ack", 32'(m1_ack), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    @(negedge clk);
    chk("rst_rel.busy_clear", 32'(busy), 32'd0);

    // Single-port vectors: writes, reads, byte merges, be ignored on reads.
    for (int unsigned i = 0; i < 11; i++)
      do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].be,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Contention: both ports saturated for 12 cycles, samples at edges 1,4,7,10.
    drive(1'b0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 10'h004, 32'h0);
    for (int unsigned n = 1; n <= 12; n++) begin
      @(negedge clk);
`ifdef DMARB_CPU_PRI_EN
      exp0 = (n % 3 == 2);
      exp1 = 1'b0;
`else
      exp0 = (n % 6 == 2);
      exp1 = (n % 6 == 5);
`endif
      chk($sformatf("cont%0d.m0_ack", n),   32'(m0_ack),   32'(exp0));
      chk($sformatf("cont%0d.m1_ack", n),   32'(m1_ack),   32'(exp1));
      chk($sformatf("cont%0d.m0_stall", n), 32'(m0_stall), 32'(!exp0));
      chk($sformatf("cont%0d.m0_rdata", n), m0_rdata, exp0 ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("cont%0d.m1_rdata", n), m1_rdata, exp1 ? 32'h1234AB78 : 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    @(negedge clk);

    // Reset during the ISSUE cycle of an m1 read: no ack ever appears.
    drive(1'b1, 1'b1, 1'b0, 4'h0, 10'h004, 32'h0);
    @(negedge clk);
    chk("midrst.issue_en", 32'(mem_en), 32'd1);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst.m1_ack", 32'(m1_ack), 32'd0);
      chk("midrst.mem_en", 32'(mem_en), 32'd0);
      chk("midrst.busy",   32'(busy),   32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    do_access("post_rst", 1'b0, 1'b0, 4'h0, 10'h010, 32'h0, 32'hDEADBEEF);

    // Stall: m0 read raised while an m1 write sits in RESP.
    drive(1'b1, 1'b1, 1'b1, 4'hF, 10'h008, 32'h11112222);
    @(negedge clk);
    @(negedge clk);
    chk("stall.m1_ack", 32'(m1_ack), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    #1;
    chk("stall.raise", 32'(m0_stall), 32'd1);
    for (int unsigned i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.m0_stall", i), 32'(m0_stall), 32'(i != 3));
      chk($sformatf("stall%0d.m0_ack", i),   32'(m0_ack),   32'(i == 3));
      chk($sformatf("stall%0d.m0_rdata", i), m0_rdata, (i == 3) ? 32'hDEADBEEF : 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("stall.dropped", 32'(m0_stall), 32'd0);
    @(negedge clk);
    do_access("stall_wr_rb", 1'b0, 1'b0, 4'h0, 10'h008, 32'h0, 32'h11112222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
